// File: rtl/param_grf.sv
// Parametrised register file: byte-enable write, same-cycle bypass, pending scoreboard, soft clear.
// Optional `define GRF_TRACE_EN prints every committed write.
module param_grf #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wbe,
    input  logic [31:0]              pc,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        pend,
    input  logic                     issue_vld,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     clr_req,
    output logic                     clr_busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            stateReg, stateNext;
    logic [ADDR_W-1:0] clrCnt;
    logic [DATA_W-1:0] regFile [DEPTH];
    logic [DEPTH-1:0]  pendReg;
    logic              idle, wrEn, issEn;
    logic [DATA_W-1:0] wrOld, wrMerged;

    assign idle     = (stateReg == IDLE);
    assign wrEn     = idle && we && !((ZERO_REG != 0) && (waddr == '0));
    assign issEn    = idle && issue_vld && !((ZERO_REG != 0) && (issue_addr == '0));
    assign wrOld    = regFile[waddr];
    assign clr_busy = (stateReg == CLEAR);

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte
            assign wrMerged[gi*8 +: 8] = wbe[gi] ? wdata[gi*8 +: 8] : wrOld[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) stateReg <= IDLE;
        else        stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (clr_req) stateNext = CLEAR;
            CLEAR:   if (&clrCnt) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Held at zero while idle so every clear sweep starts from register 0.
    always_ff @(posedge clk) begin
        if (!reset || idle) clrCnt <= '0;
        else                clrCnt <= clrCnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)     regFile <= '{default: '0};
        else if (!idle) regFile[clrCnt] <= '0;
        else if (wrEn)  regFile[waddr] <= wrMerged;
    end

    // Issue is applied after the write clear so a newer producer wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pendReg <= '0;
        end else if (!idle) begin
            pendReg[clrCnt] <= 1'b0;
        end else begin
            if (wrEn)  pendReg[waddr] <= 1'b0;
            if (issEn) pendReg[issue_addr] <= 1'b1;
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              zeroHit, byp;
            assign ra      = raddr[gi*ADDR_W +: ADDR_W];
            assign zeroHit = (ZERO_REG != 0) && (ra == '0);
            assign byp     = wrEn && (waddr == ra);
            assign rdata[gi*DATA_W +: DATA_W] = zeroHit ? '0 : (byp ? wrMerged : regFile[ra]);
            assign pend[gi] = !zeroHit && !byp && pendReg[ra];
        end
    endgenerate

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && wrEn && (wbe != '0))
            $display("%d@%h: $%d <= %h", $time, pc, waddr, wrMerged);
    end
`else
    logic unusedPc;
    assign unusedPc = ^pc;
`endif
endmodule

// File: tb/tb_param_grf.sv
// Self-checking bench for param_grf: table of single-cycle vectors through a scoreboard queue,
// plus hand-written clear, reset-abort and wide-configuration sequences.
module tb_param_grf;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe = '0;
    logic [31:0] pc = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic [1:0]  pend;
    logic        issue_vld = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        clr_req = 1'b0;
    logic        clr_busy;

    logic         weW = 1'b0;
    logic [3:0]   waddrW = '0;
    logic [63:0]  wdataW = '0;
    logic [7:0]   wbeW = '0;
    logic [11:0]  raddrW = '0;
    logic [191:0] rdataW;
    logic [2:0]   pendW;
    logic         clrBusyW;
    logic         tieOff = 1'b0;
    logic [3:0]   tieAddr = '0;

    int total = 0;
    int passed = 0;

    param_grf dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe), .pc(pc),
        .raddr(raddr), .rdata(rdata), .pend(pend), .issue_vld(issue_vld),
        .issue_addr(issue_addr), .clr_req(clr_req), .clr_busy(clr_busy)
    );

    param_grf #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(1)) dutW (
        .clk(clk), .reset(reset), .we(weW), .waddr(waddrW), .wdata(wdataW), .wbe(wbeW), .pc(pc),
        .raddr(raddrW), .rdata(rdataW), .pend(pendW), .issue_vld(tieOff),
        .issue_addr(tieAddr), .clr_req(tieOff), .clr_busy(clrBusyW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic        iss;
        logic [4:0]  iaddr;
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;
        logic [1:0]  ep;
    } vec_t;

    typedef struct packed {
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  pd;
    } exp_t;

    localparam int NV = 14;
    vec_t vecs [NV];
    exp_t expQ [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fillv(input int i);
        return {4{8'(i)}};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   cnt;

        //           we    waddr  wdata          wbe   iss   iaddr  ra0    ra1    e0             e1             ep
        vecs[0]  = '{1'b1, 5'd5,  32'h12345678, 4'hF, 1'b0, 5'd0,  5'd5,  5'd0,  32'h12345678, 32'h0,        2'b00};
        vecs[1]  = '{1'b1, 5'd5,  32'hAABBCCDD, 4'h2, 1'b0, 5'd0,  5'd5,  5'd5,  32'h1234CC78, 32'h1234CC78, 2'b00};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  5'd5,  5'd3,  32'h1234CC78, 32'h0,        2'b00};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF, 1'b1, 5'd0,  5'd0,  5'd5,  32'h0,        32'h1234CC78, 2'b00};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd7,  5'd0,  5'd7,  32'h0,        32'h0,        2'b00};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  5'd5,  5'd7,  32'h1234CC78, 32'h0,        2'b10};
        vecs[6]  = '{1'b1, 5'd7,  32'hDEADBEEF, 4'hF, 1'b0, 5'd0,  5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00};
        vecs[8]  = '{1'b1, 5'd7,  32'h11111111, 4'h1, 1'b1, 5'd7,  5'd7,  5'd0,  32'hDEADBE11, 32'h0,        2'b00};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd9,  5'd7,  5'd9,  32'hDEADBE11, 32'h0,        2'b01};
        vecs[10] = '{1'b1, 5'd9,  32'hFFFFFFFF, 4'h0, 1'b0, 5'd0,  5'd9,  5'd7,  32'h0,        32'hDEADBE11, 2'b10};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  5'd9,  5'd7,  32'h0,        32'hDEADBE11, 2'b10};
        vecs[12] = '{1'b1, 5'd5,  32'hAA0000BB, 4'h9, 1'b0, 5'd0,  5'd5,  5'd0,  32'hAA34CCBB, 32'h0,        2'b00};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  5'd5,  5'd7,  32'hAA34CCBB, 32'hDEADBE11, 2'b10};

        // Reset and read back every address on both ports.
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(31 - i), 5'(i)};
            #1;
            check($sformatf("reset rd a%0d", i), rdata, 64'h0);
            check($sformatf("reset pend a%0d", i), 64'(pend), 64'h0);
        end
        check("reset clr_busy", 64'(clr_busy), 64'h0);
        check("reset wide rd", rdataW[63:0] | rdataW[127:64] | rdataW[191:128], 64'h0);

        for (int i = 0; i < NV; i++) begin
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata; wbe = vecs[i].wbe;
            issue_vld = vecs[i].iss; issue_addr = vecs[i].iaddr;
            raddr = {vecs[i].ra1, vecs[i].ra0};
            pc = 32'h0040_3000 + 32'(i * 4);
            expQ.push_back('{vecs[i].e0, vecs[i].e1, vecs[i].ep});
            @(negedge clk);
            e = expQ.pop_front();
            check($sformatf("vec%0d rd0", i), 64'(rdata[31:0]), 64'(e.rd0));
            check($sformatf("vec%0d rd1", i), 64'(rdata[63:32]), 64'(e.rd1));
            check($sformatf("vec%0d pend", i), 64'(pend), 64'(e.pd));
            tick;
        end
        we = 1'b0; issue_vld = 1'b0;

        // Fill registers, mark $25 pending.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = fillv(i); wbe = 4'hF;
            tick;
        end
        we = 1'b0; issue_vld = 1'b1; issue_addr = 5'd25;
        tick;
        issue_vld = 1'b0;

        // Clear request alongside a write: write lands, clear begins next cycle.
        we = 1'b1; waddr = 5'd3; wdata = 32'hCAFEF00D; clr_req = 1'b1;
        @(negedge clk);
        check("clr start busy", 64'(clr_busy), 64'h0);
        tick;
        wdata = 32'h55555555; waddr = 5'd31; issue_vld = 1'b1; issue_addr = 5'd20;
        raddr = {5'd3, 5'd31};
        @(negedge clk);
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            if (cnt == 0) begin
                check("clear c0 rd31", 64'(rdata[31:0]), 64'(fillv(31)));
                check("clear c0 rd3", 64'(rdata[63:32]), 64'h00000000CAFEF00D);
                raddr = {5'd2, 5'd31};
            end
            if (cnt == 5) begin
                check("clear c5 rd31", 64'(rdata[31:0]), 64'(fillv(31)));
                check("clear c5 rd2", 64'(rdata[63:32]), 64'h0);
                check("clear c5 pend", 64'(pend), 64'h0);
            end
            cnt++;
            @(negedge clk);
        end
        we = 1'b0; issue_vld = 1'b0; clr_req = 1'b0;
        check("clear busy cycles", 64'(cnt), 64'd32);
        raddr = {5'd25, 5'd20};
        #1;
        check("post clear pend", 64'(pend), 64'h0);
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(i), 5'(i)};
            #1;
            check($sformatf("post clear rd a%0d", i), rdata, 64'h0);
        end

        // Reset during a clear aborts it.
        tick;
        we = 1'b1; waddr = 5'd31; wdata = 32'h77777777; wbe = 4'hF;
        tick;
        we = 1'b0; clr_req = 1'b1;
        tick;
        clr_req = 1'b0;
        repeat (9) tick;
        reset = 1'b0;
        @(negedge clk);
        check("abort busy before", 64'(clr_busy), 64'h1);
        tick;
        reset = 1'b1;
        raddr = {5'd31, 5'd31};
        @(negedge clk);
        check("abort busy after", 64'(clr_busy), 64'h0);
        check("abort rd31", rdata, 64'h0);
        tick;
        we = 1'b1; waddr = 5'd4; wdata = 32'h0BADF00D; raddr = {5'd0, 5'd4};
        tick;
        we = 1'b0;
        @(negedge clk);
        check("post abort write", 64'(rdata[31:0]), 64'h000000000BADF00D);

        // Wide instance: three ports on $15, bypass then stored.
        tick;
        weW = 1'b1; waddrW = 4'd15; wdataW = 64'h0123456789ABCDEF; wbeW = 8'hFF;
        raddrW = {4'd15, 4'd15, 4'd15};
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("wide byp p%0d", k), rdataW[k*64 +: 64], 64'h0123456789ABCDEF);
        tick;
        weW = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("wide rd p%0d", k), rdataW[k*64 +: 64], 64'h0123456789ABCDEF);
        check("wide pend", 64'(pendW), 64'h0);
        check("wide busy", 64'(clrBusyW), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
